// File: rtl/bisection_pkg.sv
// bisection_pkg: shared register map, field widths and sequencer states for the bisection front end
package bisection_pkg;
  localparam int COEF_W = 16;
  localparam int ALPHA_W = 20;
  localparam logic [1:0] OFF_COEF = 2'd0;
  localparam logic [1:0] OFF_CTRL = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_RESULT = 2'd3;
  localparam int CTRL_START = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_OVERRUN = 2;
  typedef enum logic [1:0] {IDLE, START, RUN} state_t;
endpackage

// File: rtl/bisection_seq.sv
// bisection_seq: pulses the core reset, counts the settle interval, then flags the alpha capture
module bisection_seq import bisection_pkg::*; #(
  parameter int SETTLE_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic pulse,
  output logic capture
);
  state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: state_n = start ? START : IDLE;
      START: begin
        state_n = RUN;
        cnt_n = 16'(SETTLE_CYCLES - 1);
      end
      RUN: begin
        state_n = (cnt == '0) ? IDLE : RUN;
        cnt_n = (cnt == '0) ? cnt : cnt - 16'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  assign busy = state != IDLE;
  assign pulse = state == START;
  assign capture = (state == RUN) && (cnt == '0);
endmodule

// File: rtl/bisection_wb_regs.sv
// bisection_wb_regs: Wishbone register front end holding coefficients, run control and the alpha result
module bisection_wb_regs import bisection_pkg::*; #(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic [COEF_W-1:0]  coef_o,
  output logic               core_rst_o,
  input  logic [ALPHA_W-1:0] alpha_i,
  output logic               irq_o
);
  logic busy, pulse, capture, irq_en, done, overrun;
  logic accept, wr, wr_coef, wr_ctrl, wr_stat, start;
  logic [1:0] off;
  logic [ALPHA_W-1:0] result;
  logic [31:0] rdata;
  assign off = wbs_adr_i[3:2];
  assign accept = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
  assign wr = accept & wbs_we_i;
  assign wr_coef = wr & (off == OFF_COEF);
  assign wr_ctrl = wr & (off == OFF_CTRL) & wbs_sel_i[0];
  assign wr_stat = wr & (off == OFF_STATUS) & wbs_sel_i[0];
  assign start = wr_ctrl & wbs_dat_i[CTRL_START];
  assign core_rst_o = wb_rst_i | pulse;
  assign rdata = (off == OFF_COEF) ? {{(32-COEF_W){1'b0}}, coef_o} :
                 (off == OFF_CTRL) ? {30'b0, irq_en, 1'b0} :
                 (off == OFF_STATUS) ? {29'b0, overrun, done, busy} :
                 {{(32-ALPHA_W){1'b0}}, result};
  bisection_seq #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_seq (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .start(start & ~busy),
    .busy(busy),
    .pulse(pulse),
    .capture(capture)
  );
  // capture and busy-time overruns are OR'd after the W1C mask so a set always beats a clear
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      coef_o <= '0;
      irq_en <= 1'b0;
      done <= 1'b0;
      overrun <= 1'b0;
      result <= '0;
      irq_o <= 1'b0;
    end else begin
      wbs_ack_o <= accept;
      wbs_dat_o <= (accept & ~wbs_we_i) ? rdata : '0;
      if (wr_coef & ~busy & wbs_sel_i[0]) coef_o[7:0] <= wbs_dat_i[7:0];
      if (wr_coef & ~busy & wbs_sel_i[1]) coef_o[15:8] <= wbs_dat_i[15:8];
      if (wr_ctrl) irq_en <= wbs_dat_i[CTRL_IRQ_EN];
      done <= capture | (done & ~(wr_stat & wbs_dat_i[ST_DONE]));
      overrun <= (busy & (wr_coef | start)) | (overrun & ~(wr_stat & wbs_dat_i[ST_OVERRUN]));
      if (capture) result <= alpha_i;
      irq_o <= done & irq_en;
    end
  end
endmodule

// File: tb/tb_bisection_wb_regs.sv
// tb_bisection_wb_regs: randomized scoreboard bench against a cycle-count register model
module tb_bisection_wb_regs;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int S = 4;
  logic clk = 0, rst = 1, stb = 0, cyc = 0, we = 0;
  logic [3:0] sel = 0;
  logic [31:0] adr = 0, wdat = 0, rdat;
  logic ack, core_rst, irq;
  logic [15:0] coef;
  logic [19:0] alpha = 0;
  int checks = 0, errors = 0, now = 0;
  logic [31:0] exp_q[$];
  int pulse_q[$];
  logic [15:0] m_coef = 0;
  bit m_irq_en = 0, m_done = 0, m_over = 0, m_run = 0;
  logic [19:0] m_result = 0, m_alpha = 0;
  int m_end = 0;

  always #5 clk = ~clk;

  bisection_wb_regs #(.ADDR_BASE(BASE), .SETTLE_CYCLES(S)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .coef_o(coef), .core_rst_o(core_rst), .alpha_i(alpha), .irq_o(irq)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at edge %0d", nm, act, exp, now);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    now++;
    #1;
  endtask

  // a run started at edge E captures at edge E+S+1; anything seen at a later edge sees it finished
  task automatic sync(input int a);
    if (m_run && m_end < a) begin
      m_run = 0;
      m_done = 1;
      m_result = m_alpha;
    end
  endtask

  task automatic m_reset();
    m_coef = 0; m_irq_en = 0; m_done = 0; m_over = 0; m_run = 0; m_result = 0;
  endtask

  task automatic m_edge(input int a, input logic w, input logic [1:0] off, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd);
    bit busy, cap;
    sync(a);
    busy = m_run;
    cap = m_run && m_end == a;
    rd = off == 2'd0 ? {16'h0, m_coef} : off == 2'd1 ? {30'h0, m_irq_en, 1'b0} :
         off == 2'd2 ? {29'h0, m_over, m_done, busy} : {12'h0, m_result};
    if (w && off == 2'd0) begin
      if (busy) m_over = 1;
      else begin
        if (s[0]) m_coef[7:0] = d[7:0];
        if (s[1]) m_coef[15:8] = d[15:8];
      end
    end
    if (w && off == 2'd1 && s[0]) begin
      m_irq_en = d[1];
      if (d[0] && busy) m_over = 1;
      if (d[0] && !busy) begin
        m_run = 1;
        m_end = a + S + 1;
        m_alpha = alpha;
        pulse_q.push_back(a);
      end
    end
    if (w && off == 2'd2 && s[0]) begin
      if (d[1]) m_done = 0;
      if (d[2]) m_over = 0;
    end
    if (cap) begin
      m_run = 0;
      m_done = 1;
      m_result = m_alpha;
    end
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    bit hit;
    hit = a[31:4] == BASE[31:4];
    stb = 1; cyc = 1; we = w; adr = a; wdat = d; sel = s;
    tick();
    if (hit) begin
      m_edge(now, w, a[3:2], d, s, rd);
      exp_q.push_back(w ? 32'h0 : rd);
    end else chk("miss_no_ack", {31'h0, ack}, 32'h0);
    stb = 0; cyc = 0; we = 0;
    tick();
  endtask

  task automatic wr_reg(input logic [1:0] off, input logic [31:0] d, input logic [3:0] s);
    xfer(1'b1, BASE | {28'h0, off, 2'b00}, d, s);
  endtask

  task automatic rd_reg(input logic [1:0] off);
    xfer(1'b0, BASE | {28'h0, off, 2'b00}, 32'h0, 4'hF);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4 * S + 8 && m_run && now <= m_end; i++) tick();
    tick();
    tick();
    sync(now + 1);
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    tick();
    m_reset();
    pulse_q.delete();
    chk("core_rst_in_reset", {31'h0, core_rst}, 32'h1);
    for (int i = 1; i < n; i++) tick();
    rst = 0;
  endtask

  always @(negedge clk) begin
    if (now > 0) begin
      if (ack) begin
        if (exp_q.size() == 0) chk("unexpected_ack", {31'h0, ack}, 32'h0);
        else chk("read_data", rdat, exp_q.pop_front());
      end else chk("dat_idle_zero", rdat, 32'h0);
      chk("coef_o", {16'h0, coef}, {16'h0, m_coef});
      if (core_rst && !rst) begin
        if (pulse_q.size() == 0) chk("unexpected_core_rst", {31'h0, core_rst}, 32'h0);
        else chk("core_rst_edge", 32'(now), 32'(pulse_q.pop_front()));
      end
    end
  end

  initial begin
    do_reset(3);
    chk("irq_after_reset", {31'h0, irq}, 32'h0);
    chk("ack_after_reset", {31'h0, ack}, 32'h0);
    for (int i = 0; i < 4; i++) rd_reg(2'(i));
    wr_reg(2'd0, 32'h0000_A5C3, 4'b0001);
    chk("coef_sel0", {16'h0, coef}, 32'h0000_00C3);
    rd_reg(2'd0);
    wr_reg(2'd0, 32'h0000_A5C3, 4'b0011);
    chk("coef_sel01", {16'h0, coef}, 32'h0000_A5C3);
    rd_reg(2'd0);
    alpha = 20'h5_1234;
    wr_reg(2'd1, 32'h3, 4'h1);
    tick();
    rd_reg(2'd3);
    rd_reg(2'd3);
    rd_reg(2'd3);
    wait_idle();
    chk("irq_after_done", {31'h0, irq}, 32'h1);
    chk("result_model", {12'h0, m_result}, 32'h0005_1234);
    rd_reg(2'd2);
    wr_reg(2'd2, 32'h2, 4'h1);
    tick();
    chk("irq_after_w1c", {31'h0, irq}, 32'h0);
    alpha = 20'h0_ABCD;
    wr_reg(2'd1, 32'h3, 4'h1);
    wr_reg(2'd0, 32'h0000_1234, 4'b0011);
    rd_reg(2'd2);
    wait_idle();
    chk("coef_kept", {16'h0, coef}, 32'h0000_A5C3);
    rd_reg(2'd2);
    wr_reg(2'd1, 32'h3, 4'h1);
    wr_reg(2'd1, 32'h3, 4'h1);
    rd_reg(2'd2);
    wait_idle();
    rd_reg(2'd2);
    wr_reg(2'd2, 32'h6, 4'h1);
    rd_reg(2'd2);
    wr_reg(2'd1, 32'h3, 4'h1);
    tick();
    do_reset(1);
    rd_reg(2'd3);
    rd_reg(2'd2);
    wait_idle();
    chk("irq_after_midrun_reset", {31'h0, irq}, 32'h0);
    chk("result_after_midrun_reset", {12'h0, m_result}, 32'h0);
    alpha = 20'hF_00D1;
    wr_reg(2'd1, 32'h1, 4'h1);
    wait_idle();
    alpha = 20'h3_3333;
    wr_reg(2'd1, 32'h1, 4'h1);
    rd_reg(2'd3);
    xfer(1'b0, BASE + 32'h40, 32'h0, 4'hF);
    xfer(1'b1, BASE + 32'h40, 32'hFFFF, 4'hF);
    wait_idle();
    stb = 1; cyc = 1; we = 0; adr = BASE; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] rd;
      tick();
      if (i % 2 == 0) begin
        m_edge(now, 1'b0, 2'd0, 32'h0, 4'hF, rd);
        exp_q.push_back(rd);
      end
    end
    stb = 0; cyc = 0;
    tick();
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [31:0] d;
      r = $urandom_range(0, 9);
      d = $urandom;
      if (!m_run) alpha = 20'($urandom);
      if (r == 0) tick();
      else if (r == 1) xfer(1'($urandom), BASE + 32'h10 * $urandom_range(1, 8), d, 4'($urandom));
      else if (r < 6) rd_reg(2'($urandom));
      else wr_reg(2'($urandom), d, 4'($urandom));
    end
    wait_idle();
    tick();
    chk("irq_final", {31'h0, irq}, {31'h0, m_done & m_irq_en});
    chk("ack_queue_drained", 32'(exp_q.size()), 32'h0);
    chk("pulse_queue_drained", 32'(pulse_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
